// File: rtl/dc_fifo_pkg.sv
// Shared definitions for the token-based dual-clock channel buffer halves.
// Holds the fill-width helper and the default token vector type.
package dc_fifo_pkg;

`ifndef DC_FIFO_BUFFER_DEPTH
  `define DC_FIFO_BUFFER_DEPTH 8
`endif

  localparam int DC_DEFAULT_DEPTH = `DC_FIFO_BUFFER_DEPTH;

  // Token vector for the default depth; modules with a custom depth declare their own.
  typedef logic [DC_DEFAULT_DEPTH-1:0] dc_token_t;

  // Occupancy can reach the full depth, so one extra bit over the index width.
  function automatic int fill_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dc_ptr_sync.sv
// Two-flop synchroniser for toggle-encoded pointer/token vectors.
// Bit-wise sync is safe because the far side changes at most one bit per cycle.
module dc_ptr_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d_i;
      r_s2 <= r_s1;
    end
  end

  assign q_o = r_s2;

endmodule

// File: rtl/dc_token_src.sv
// Producer half of the token-based dual-clock channel buffer: stores accepted
// beats, toggles one write token per slot write, and tracks frees via synced read pointers.
module dc_token_src
  import dc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,
  localparam int FILL_W      = fill_width(BUFFER_DEPTH),
  localparam int IDX_W       = $clog2(BUFFER_DEPTH)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [DATA_WIDTH-1:0]              data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [BUFFER_DEPTH-1:0]            writetoken_o,
  input  logic [BUFFER_DEPTH-1:0]            readpointer_i,
  output logic [BUFFER_DEPTH*DATA_WIDTH-1:0] data_async_o,
  output logic [FILL_W-1:0]                  fill_o
);

  typedef logic [BUFFER_DEPTH-1:0] token_t;

  logic [IDX_W-1:0]      r_widx;
  token_t                r_wtok;
  logic [DATA_WIDTH-1:0] r_buf [BUFFER_DEPTH];

  token_t                w_rp_sync;
  token_t                w_full;
  logic                  w_write;
  logic [FILL_W-1:0]     w_fill;

  dc_ptr_sync #(
    .WIDTH (BUFFER_DEPTH)
  ) u_rp_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (readpointer_i),
    .q_o    (w_rp_sync)
  );

  // Handshake: a beat transfers on a rising edge where valid_i && ready_o; ready_o
  // reflects only whether the slot at the write index is empty and never looks at valid_i.
  assign w_full  = r_wtok ^ w_rp_sync;
  assign ready_o = (r_wtok[r_widx] == w_rp_sync[r_widx]);
  assign w_write = valid_i && ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_widx <= '0;
      r_wtok <= '0;
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_write) begin
      r_buf[r_widx]  <= data_i;
      r_wtok[r_widx] <= ~r_wtok[r_widx];
      r_widx         <= (r_widx == IDX_W'(BUFFER_DEPTH - 1)) ? '0 : r_widx + IDX_W'(1);
    end
  end

  // Over-reports by frees still in the synchroniser, never under-reports.
  always_comb begin
    w_fill = '0;
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      w_fill = w_fill + FILL_W'(w_full[i]);
    end
  end

  assign fill_o       = w_fill;
  assign writetoken_o = r_wtok;

  for (genvar g = 0; g < BUFFER_DEPTH; g++) begin : g_data_out
    assign data_async_o[g*DATA_WIDTH +: DATA_WIDTH] = r_buf[g];
  end

`ifndef SYNTHESIS
  // A synchronised free may only ever land on a slot that was full.
  a_free_only_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((w_rp_sync ^ $past(w_rp_sync)) & ~$past(w_full)) == '0);
`endif

endmodule
